// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer: FSM states, character codes,
// unit multipliers and the ROM entry format.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        LGAP,
        WGAP
    } state_t;

    localparam logic [5:0] CHAR_DIGIT0 = 6'd26;
    localparam logic [5:0] CHAR_SPACE  = 6'd36;

    localparam int DASH_UNITS = 3;
    localparam int LGAP_UNITS = 3;
    localparam int WGAP_UNITS = 7;

    // pat holds len elements right-aligned, first element in bit len-1, 1 = dash
    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pat;
    } morse_code_t;

    function automatic morse_code_t mk_code(input logic [2:0] len, input logic [4:0] pat);
        morse_code_t c;
        c.valid = 1'b1;
        c.len   = len;
        c.pat   = pat;
        return c;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character-code to Morse pattern lookup.
// Digits 0-9 (codes 26-35) are present only when MORSE_DIGITS_EN is defined.
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0]  chr,
    output morse_code_t code
);

    always_comb begin
        code = '0;
        case (chr)
            6'd0:  code = mk_code(3'd2, 5'b00001); // A .-
            6'd1:  code = mk_code(3'd4, 5'b01000); // B -...
            6'd2:  code = mk_code(3'd4, 5'b01010); // C -.-.
            6'd3:  code = mk_code(3'd3, 5'b00100); // D -..
            6'd4:  code = mk_code(3'd1, 5'b00000); // E .
            6'd5:  code = mk_code(3'd4, 5'b00010); // F ..-.
            6'd6:  code = mk_code(3'd3, 5'b00110); // G --.
            6'd7:  code = mk_code(3'd4, 5'b00000); // H ....
            6'd8:  code = mk_code(3'd2, 5'b00000); // I ..
            6'd9:  code = mk_code(3'd4, 5'b00111); // J .---
            6'd10: code = mk_code(3'd3, 5'b00101); // K -.-
            6'd11: code = mk_code(3'd4, 5'b00100); // L .-..
            6'd12: code = mk_code(3'd2, 5'b00011); // M --
            6'd13: code = mk_code(3'd2, 5'b00010); // N -.
            6'd14: code = mk_code(3'd3, 5'b00111); // O ---
            6'd15: code = mk_code(3'd4, 5'b00110); // P .--.
            6'd16: code = mk_code(3'd4, 5'b01101); // Q --.-
            6'd17: code = mk_code(3'd3, 5'b00010); // R .-.
            6'd18: code = mk_code(3'd3, 5'b00000); // S ...
            6'd19: code = mk_code(3'd1, 5'b00001); // T -
            6'd20: code = mk_code(3'd3, 5'b00001); // U ..-
            6'd21: code = mk_code(3'd4, 5'b00001); // V ...-
            6'd22: code = mk_code(3'd3, 5'b00011); // W .--
            6'd23: code = mk_code(3'd4, 5'b01001); // X -..-
            6'd24: code = mk_code(3'd4, 5'b01011); // Y -.--
            6'd25: code = mk_code(3'd4, 5'b01100); // Z --..
`ifdef MORSE_DIGITS_EN
            CHAR_DIGIT0 + 6'd0: code = mk_code(3'd5, 5'b11111);
            CHAR_DIGIT0 + 6'd1: code = mk_code(3'd5, 5'b01111);
            CHAR_DIGIT0 + 6'd2: code = mk_code(3'd5, 5'b00111);
            CHAR_DIGIT0 + 6'd3: code = mk_code(3'd5, 5'b00011);
            CHAR_DIGIT0 + 6'd4: code = mk_code(3'd5, 5'b00001);
            CHAR_DIGIT0 + 6'd5: code = mk_code(3'd5, 5'b00000);
            CHAR_DIGIT0 + 6'd6: code = mk_code(3'd5, 5'b10000);
            CHAR_DIGIT0 + 6'd7: code = mk_code(3'd5, 5'b11000);
            CHAR_DIGIT0 + 6'd8: code = mk_code(3'd5, 5'b11100);
            CHAR_DIGIT0 + 6'd9: code = mk_code(3'd5, 5'b11110);
`endif
            // Space is a legal code with no elements; the keyer turns it into a word gap
            CHAR_SPACE: code = mk_code(3'd0, 5'b00000);
            default:    code = '0;
        endcase
    end

endmodule

// File: rtl/morse_tx.sv
// Handshaked Morse keyer with ITU timing, word gaps, error pulse and abort.
// Digit support is controlled by MORSE_DIGITS_EN (see morse_rom).
module morse_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 100,
    parameter int CNT_W       = $clog2(7 * UNIT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [5:0] in_char,
    output logic       in_ready,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Counter reload values: a state lasting N cycles loads N-1 and exits at 0
    localparam logic [CNT_W-1:0] UNIT_LD = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LGAP_LD = CNT_W'(LGAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WGAP_LD = CNT_W'(WGAP_UNITS * UNIT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [2:0]       len, len_n;
    logic [4:0]       sh, sh_n;
    logic [4:0]       first_sh;
    logic             accept;
    morse_code_t      code;

    morse_rom u_rom (
        .chr  (in_char),
        .code (code)
    );

    assign in_ready = (state == IDLE) && en && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign done     = ((state == LGAP) || (state == WGAP)) && (cnt == '0) && en && !rst;
    // Left-justify the pattern so the current element is always sh[4]
    assign first_sh = code.pat << (3'd5 - code.len);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        len_n   = len;
        sh_n    = sh;
        if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
        end
        case (state)
            IDLE: begin
                if (accept && code.valid) begin
                    if (in_char == CHAR_SPACE) begin
                        state_n = WGAP;
                        cnt_n   = WGAP_LD;
                    end else begin
                        state_n = MARK;
                        len_n   = code.len;
                        idx_n   = 3'd0;
                        sh_n    = first_sh;
                        cnt_n   = first_sh[4] ? DASH_LD : UNIT_LD;
                    end
                end
            end
            MARK: begin
                if (cnt == '0) begin
                    if (idx == len - 3'd1) begin
                        state_n = LGAP;
                        cnt_n   = LGAP_LD;
                    end else begin
                        state_n = GAP;
                        cnt_n   = UNIT_LD;
                        idx_n   = idx + 3'd1;
                        sh_n    = sh << 1;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = MARK;
                    cnt_n   = sh[4] ? DASH_LD : UNIT_LD;
                end
            end
            LGAP, WGAP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!en && (state != IDLE)) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            out   <= (state_n == MARK);
            err   <= accept && !code.valid;
        end
        cnt <= cnt_n;
        idx <= idx_n;
        len <= len_n;
        sh  <= sh_n;
    end

endmodule

// File: tb/tb_morse_tx.sv
// Directed testbench for morse_tx at UNIT_CYCLES=4; per-cycle traces are
// compared against hand-derived expected waveforms.
module tb_morse_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [5:0] in_char;
    logic       in_ready;
    logic       out;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    morse_tx #(.UNIT_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_ready (in_ready),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [5:0] ch);
        @(negedge clk);
        in_char  = ch;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic capture(input int n, output logic [127:0] o, output logic [127:0] b,
                           output logic [127:0] d, output logic [127:0] e, output logic [127:0] r);
        o = '0; b = '0; d = '0; e = '0; r = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o[i] = out; b[i] = busy; d[i] = done; e[i] = err; r[i] = in_ready;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_char = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out !== 1'b0)      begin bad++; $display("FAIL rst_out: got %b want 0", out); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_letter_a;
        logic [127:0] o, b, d, e, r, eo, eb, ed;
        eo = '0; eb = '0; ed = '0;
        for (int i = 0; i < 40; i++) begin
            eo[i] = (i < 4) || (i >= 8 && i < 20);
            eb[i] = (i < 32);
            ed[i] = (i == 31);
        end
        send(6'd0);
        capture(40, o, b, d, e, r);
        total++; if (o !== eo)   begin bad++; $display("FAIL a_out: got %h want %h", o, eo); end
        total++; if (b !== eb)   begin bad++; $display("FAIL a_busy: got %h want %h", b, eb); end
        total++; if (d !== ed)   begin bad++; $display("FAIL a_done: got %h want %h", d, ed); end
        total++; if (e !== '0)   begin bad++; $display("FAIL a_err: got %h want 0", e); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] o, b, d, r, eo, eb, ed, er;
        o = '0; b = '0; d = '0; r = '0; eo = '0; eb = '0; ed = '0; er = '0;
        for (int i = 0; i < 45; i++) begin
            eo[i] = (i < 4) || (i >= 17 && i < 29);
            er[i] = (i == 16) || (i >= 41);
            eb[i] = !er[i];
            ed[i] = (i == 15) || (i == 40);
        end
        @(negedge clk);
        in_char  = 6'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_char = 6'd19;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            o[i] = out; b[i] = busy; d[i] = done; r[i] = in_ready;
            if (i == 17) in_valid = 1'b0;
        end
        total++; if (o !== eo) begin bad++; $display("FAIL b2b_out: got %h want %h", o, eo); end
        total++; if (r !== er) begin bad++; $display("FAIL b2b_ready: got %h want %h", r, er); end
        total++; if (b !== eb) begin bad++; $display("FAIL b2b_busy: got %h want %h", b, eb); end
        total++; if (d !== ed) begin bad++; $display("FAIL b2b_done: got %h want %h", d, ed); end
    endtask

    task automatic test_space;
        logic [127:0] o, b, d, e, r, eb, ed;
        eb = '0; ed = '0;
        for (int i = 0; i < 32; i++) begin
            eb[i] = (i < 28);
            ed[i] = (i == 27);
        end
        send(6'd36);
        capture(32, o, b, d, e, r);
        total++; if (o !== '0) begin bad++; $display("FAIL space_out: got %h want 0", o); end
        total++; if (b !== eb) begin bad++; $display("FAIL space_busy: got %h want %h", b, eb); end
        total++; if (d !== ed) begin bad++; $display("FAIL space_done: got %h want %h", d, ed); end
    endtask

    task automatic test_invalid;
        logic [127:0] o, b, d, e, r, ee, er;
        ee = '0; er = '0;
        for (int i = 0; i < 4; i++) begin
            ee[i] = (i == 0);
            er[i] = 1'b1;
        end
        send(6'd40);
        capture(4, o, b, d, e, r);
        total++; if (e !== ee) begin bad++; $display("FAIL inv_err: got %h want %h", e, ee); end
        total++; if (b !== '0) begin bad++; $display("FAIL inv_busy: got %h want 0", b); end
        total++; if (o !== '0) begin bad++; $display("FAIL inv_out: got %h want 0", o); end
        total++; if (r !== er) begin bad++; $display("FAIL inv_ready: got %h want %h", r, er); end
    endtask

    task automatic test_digit_zero;
        logic [127:0] o, b, d, e, r, eo, eb, ed, ee;
        eo = '0; eb = '0; ed = '0; ee = '0;
`ifdef MORSE_DIGITS_EN
        for (int i = 0; i < 96; i++) begin
            eo[i] = (i < 80) && ((i % 16) < 12);
            eb[i] = (i < 88);
            ed[i] = (i == 87);
        end
`else
        ee[0] = 1'b1;
`endif
        send(6'd26);
        capture(96, o, b, d, e, r);
        total++; if (o !== eo) begin bad++; $display("FAIL dig0_out: got %h want %h", o, eo); end
        total++; if (b !== eb) begin bad++; $display("FAIL dig0_busy: got %h want %h", b, eb); end
        total++; if (d !== ed) begin bad++; $display("FAIL dig0_done: got %h want %h", d, ed); end
        total++; if (e !== ee) begin bad++; $display("FAIL dig0_err: got %h want %h", e, ee); end
    endtask

    task automatic test_abort;
        logic [127:0] o, b, d, e, r, eo, eb, ed;
        o = '0; b = '0; d = '0; eo = '0; eb = '0;
        for (int i = 0; i < 20; i++) begin
            eo[i] = (i <= 5);
            eb[i] = (i <= 5);
        end
        send(6'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            o[i] = out; b[i] = busy; d[i] = done;
            if (i == 5) en = 1'b0;
        end
        total++; if (o !== eo) begin bad++; $display("FAIL abort_out: got %h want %h", o, eo); end
        total++; if (b !== eb) begin bad++; $display("FAIL abort_busy: got %h want %h", b, eb); end
        total++; if (d !== '0) begin bad++; $display("FAIL abort_done: got %h want 0", d); end
        en = 1'b1;
        eo = '0; eb = '0; ed = '0;
        for (int i = 0; i < 60; i++) begin
            eo[i] = (i < 12) || (i >= 16 && i < 20) || (i >= 24 && i < 36) || (i >= 40 && i < 44);
            eb[i] = (i < 56);
            ed[i] = (i == 55);
        end
        send(6'd2);
        capture(60, o, b, d, e, r);
        total++; if (o !== eo) begin bad++; $display("FAIL c_out: got %h want %h", o, eo); end
        total++; if (b !== eb) begin bad++; $display("FAIL c_busy: got %h want %h", b, eb); end
        total++; if (d !== ed) begin bad++; $display("FAIL c_done: got %h want %h", d, ed); end
    endtask

    task automatic test_reset_midchar;
        send(6'd19);
        repeat (3) @(negedge clk);
        total++; if (out !== 1'b1) begin bad++; $display("FAIL mid_pre_out: got %b want 1", out); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (out !== 1'b0)      begin bad++; $display("FAIL mid_rst_out: got %b want 0", out); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready: got %b want 1", in_ready); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL mid_release_done: got %b want 0", done); end
    endtask

    initial begin
        test_reset;
        test_letter_a;
        test_back_to_back;
        test_space;
        test_invalid;
        test_digit_zero;
        test_abort;
        test_reset_midchar;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_tx.md
# morse_tx

Parametrised Morse keyer that converts a stream of character codes into an on/off keying output with standard ITU timing.
- Timing: dot = 1 unit, dash = 3, intra-character gap = 1, letter gap = 3, word gap = 7.
- Characters arrive over a valid/ready handshake, one per transaction.
- Supersedes the fixed-timing single-character generator and adds word gaps, error reporting, abort and handshaked back-to-back streaming.
- Sits between the character source (UART/CPU register) and the key/LED driver.

## Interface
- UNIT_CYCLES, 100: clock cycles per Morse time unit; must be ≥ 1.
- CNT_W, $clog2(7*UNIT_CYCLES+1): width of the unit/element counter; derived, do not override.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  block enable; low aborts any character in progress and blocks acceptance.
- in_valid  input  1  character code valid.
- in_char  input  6  character code: 0–25 = A–Z, 26–35 = digits 0–9, 36 = space (word gap), 37–63 invalid.
- in_ready  output  1  block can accept a character; equals (state==IDLE && en && !rst).
- out  output  1  keying output, registered; 1 = mark.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse on the final cycle of a character's trailing gap.
- err  output  1  one-cycle pulse, the cycle after an invalid code is accepted.

## Operation
- Accept when in_valid && in_ready. The code is looked up to {len[2:0], pat[4:0]}.
  - len is 1–5.
  - pat is MSB-first within the len elements; 1 = dash.
- States and transitions:
  - IDLE: out=0. On valid accept, go to MARK; on space, go to WGAP; on invalid code, stay in IDLE and pulse err next cycle.
  - MARK: out=1 for UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash). When done, go to GAP if elements remain, else LGAP.
  - GAP: out=0 for UNIT_CYCLES, then MARK with the next element.
  - LGAP: out=0 for 3*UNIT_CYCLES. done pulses on the last cycle; then IDLE.
  - WGAP: out=0 for 7*UNIT_CYCLES. done pulses on the last cycle; then IDLE.
- The element index counts 0..len-1. The counter reloads on every state change and counts down to 0.
- Abort: en=0 in any non-IDLE state forces IDLE and out=0 on the next edge. done does not pulse.
- rst mid-character behaves like abort and also clears err/done.
- in_char is ignored unless the handshake completes; changing it mid-character has no effect.

## Timing
- Reset values: out=0, busy=0, done=0, err=0, in_ready=0 while rst is high, state=IDLE.
- Accept at edge t: busy=1 and out=1 (first mark) from cycle t+1.
- For a space, out stays 0 and busy=1 from t+1.
- Low time between the last mark of one letter and the first mark of the next, under continuous in_valid, is 3*UNIT_CYCLES + 1 cycle (one IDLE cycle).
- Total busy cycles for a character:
  - letter: sum(mark lengths) + (len-1)*UNIT_CYCLES + 3*UNIT_CYCLES
  - space: 7*UNIT_CYCLES
- err pulses at t+1 for an invalid code accepted at t. in_ready stays high and busy stays 0.
- UNIT_CYCLES=1 must work: every state lasts exactly its unit count, with no extra cycles.

## Configuration
- MORSE_DIGITS_EN defined: codes 26–35 map to ITU digits 0–9.
  - Examples: 0 = "-----", 1 = ".----", 5 = ".....".
- MORSE_DIGITS_EN undefined: codes 26–35 are invalid and produce an err pulse. The ROM contains letters and space only.

## Structure
- Package morse_pkg holds:
  - state enum {IDLE, MARK, GAP, LGAP, WGAP};
  - code constants (CHAR_SPACE=36, CHAR_DIGIT0=26);
  - unit multipliers (DASH_UNITS=3, LGAP_UNITS=3, WGAP_UNITS=7);
  - the struct {valid, len, pat}.
- Sub-module morse_rom: purely combinational 6-bit code → {valid, len[2:0], pat[4:0]}. The MORSE_DIGITS_EN guard lives here.
- The top module morse_tx holds the FSM, counter, element index and output registers.

## Test plan
All scenarios use UNIT_CYCLES=4.
- 'A' (0): out high 4, low 4, high 12, then low 12; done pulses in busy cycle 32; then busy=0.
- 'E' (4) then 'T' (19), in_valid held: E mark 4 cycles; low 12+1; T mark 12; in_ready high only in the IDLE cycles.
- Space (36): out stays 0; busy for exactly 28 cycles; done in the last cycle.
- Invalid 40: err pulses one cycle after accept; busy stays 0; out stays 0.
- '0' (26):
  - with MORSE_DIGITS_EN: five 12-cycle marks; 88 busy cycles total.
  - without it: err pulse, no output.
- 'B' (1) with en dropped during the first dash: out=0 the next cycle; IDLE; no done. Re-enabling and sending 'C' (2) gives the full, correct pattern.
